aa_fir_8tap: RTL and testbench



---
 rtl/aa_fir_8tap.sv | 108 ++++++++++
 tb/tb_aa_fir_8tap.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aa_fir_8tap.sv
// rtl/aa_fir_8tap.sv - 8-tap symmetric anti-aliasing FIR (unity DC gain, 3-cycle pipeline, valid tag)
// Define AA_FIR_SAT_EN to clamp the output to [-128,127]; otherwise the output wraps.
module aa_fir_8tap #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x,
  output logic             y_valid,
  output logic [WIDTH-1:0] y
);

  logic [7:0][WIDTH-1:0] d;
  logic signed [WIDTH:0] p0, p1, p2, p3;
  logic signed [15:0]    acc;
  logic signed [15:0]    acc_next;
  logic signed [15:0]    rnd;
  logic signed [8:0]     r;
  logic [WIDTH-1:0]      y_next;
  logic                  v_d, v_p, v_a;
  logic                  unused_bits;

  function automatic logic signed [15:0] sx(input logic signed [WIDTH:0] v);
    return 16'(v);
  endfunction

  // Delay line only advances on accepted samples, so input gaps leave the history intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d <= '0;
    end else if (x_valid) begin
      d <= {d[6:0], x};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      p0 <= {d[0][WIDTH-1], d[0]} + {d[7][WIDTH-1], d[7]};
      p1 <= {d[1][WIDTH-1], d[1]} + {d[6][WIDTH-1], d[6]};
      p2 <= {d[2][WIDTH-1], d[2]} + {d[5][WIDTH-1], d[5]};
      p3 <= {d[3][WIDTH-1], d[3]} + {d[4][WIDTH-1], d[4]};
    end
  end

  // -2*p0 + 18*p2 + 48*p3 as shift-adds; the p1 tap has a zero coefficient.
  always_comb begin
    acc_next = (sx(p2) <<< 4) + (sx(p2) <<< 1)
             + (sx(p3) <<< 5) + (sx(p3) <<< 4)
             - (sx(p0) <<< 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  // Adding half an LSB before the arithmetic shift rounds half toward +inf.
  always_comb begin
    rnd = acc + 16'sd64;
    r   = rnd[15:7];
  end

`ifdef AA_FIR_SAT_EN
  always_comb begin
    if (r > 9'sd127) begin
      y_next = 8'h7f;
    end else if (r < -9'sd128) begin
      y_next = 8'h80;
    end else begin
      y_next = r[WIDTH-1:0];
    end
  end
  assign unused_bits = ^{rnd[6:0], p1};
`else
  always_comb begin
    y_next = r[WIDTH-1:0];
  end
  assign unused_bits = ^{rnd[6:0], r[8], p1};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_d     <= 1'b0;
      v_p     <= 1'b0;
      v_a     <= 1'b0;
      y_valid <= 1'b0;
      y       <= '0;
    end else begin
      v_d     <= x_valid;
      v_p     <= v_d;
      v_a     <= v_p;
      y_valid <= v_a;
      if (v_a) begin
        y <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_aa_fir_8tap.sv
// tb/tb_aa_fir_8tap.sv - self-checking bench for aa_fir_8tap (table vectors, corner sequences, random vs model)
module tb_aa_fir_8tap;

  typedef struct {
    logic v;
    int   x;
    logic ev;
    int   ey;
  } vec_t;

  typedef struct {
    int due;
    int val;
  } pend_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       x_valid;
  logic [7:0] x;
  logic       y_valid;
  logic [7:0] y;

  int    coef[8]    = '{-2, 0, 18, 48, 48, 18, 0, -2};
  int    imp_seq[9] = '{-1, 0, 9, 24, 24, 9, 0, -1, 0};
  int    hist[8];
  pend_t pq[$];
  vec_t  tbl[12];
  int    cyc;
  logic  exp_valid;
  int    exp_y;
  int    n_checks;
  int    n_fail;

  always #5 clk = ~clk;

  aa_fir_8tap #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .x_valid (x_valid),
    .x       (x),
    .y_valid (y_valid),
    .y       (y)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct convolution of the accepted-sample history, then the output limiting rule.
  function automatic int ref_y();
    int acc;
    int r;
    logic signed [7:0] w;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += coef[k] * hist[k];
    r = (acc + 64) >>> 7;
`ifdef AA_FIR_SAT_EN
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
`else
    w = 8'(r);
    return int'(w);
`endif
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    pq.delete();
    exp_valid = 1'b0;
    exp_y = 0;
  endfunction

  task automatic tick(input logic v, input int xv);
    x_valid = v;
    x = 8'(xv);
    @(posedge clk);
    cyc++;
    if (v) begin
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = xv;
      pq.push_back('{cyc + 3, ref_y()});
    end
    exp_valid = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_y = pq[0].val;
      void'(pq.pop_front());
    end
    @(negedge clk);
    check("y_valid", int'(y_valid), int'(exp_valid));
    check("y", int'($signed(y)), exp_y);
  endtask

  // Called at a falling edge; reset rises mid-cycle and must clear outputs with no clock edge.
  task automatic pulse_reset(input int cycles);
    #2 reset = 1'b1;
    #1;
    check("async y", int'($signed(y)), 0);
    check("async y_valid", int'(y_valid), 0);
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("rst y", int'($signed(y)), 0);
      check("rst y_valid", int'(y_valid), 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    int k;
    int ovf_seq[8];
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    x_valid  = 1'b0;
    x        = 8'd0;
    model_clear();

    for (int i = 0; i < 12; i++) begin
      tbl[i].v  = 1'b1;
      tbl[i].x  = (i == 0) ? 64 : 0;
      tbl[i].ev = (i >= 3);
      tbl[i].ey = (i >= 3) ? imp_seq[i-3] : 0;
    end

    repeat (2) @(negedge clk);
    check("reset y", int'($signed(y)), 0);
    check("reset y_valid", int'(y_valid), 0);
    reset = 1'b0;

    // Reset with x=55 held valid, then nothing until 3 cycles after the next sample.
    for (int i = 0; i < 6; i++) tick(1'b1, 55);
    check("pre-reset y nonzero", int'(y != 8'd0), 1);
    pulse_reset(1);
    for (int i = 0; i < 4; i++) tick(1'b0, 55);

    // Impulse table; reset released with x_valid=1 so the first edge accepts the 64.
    pulse_reset(1);
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].v, tbl[i].x);
      check("imp y_valid", int'(y_valid), int'(tbl[i].ev));
      check("imp y", int'($signed(y)), tbl[i].ey);
    end

    // Gapped impulse: same output values, valid delayed exactly 3 cycles.
    pulse_reset(2);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) tick(1'b1, (i == 0) ? 64 : 0);
      else tick(1'b0, int'($urandom_range(0, 255)) - 128);
      check("gap y_valid", int'(y_valid), int'(i >= 3 && (i % 2) == 1));
      if (y_valid && k < 9) begin
        check("gap y", int'($signed(y)), imp_seq[k]);
        k++;
      end
    end
    check("gap count", k, 9);

    // Mid-stream reset kills the remaining taps; the next impulse replays in full.
    pulse_reset(1);
    tick(1'b1, 64);
    for (int i = 0; i < 5; i++) tick(1'b1, 0);
    check("mid pre y", int'($signed(y)), 9);
    pulse_reset(2);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 0);
      check("mid tail y", int'($signed(y)), 0);
    end
    k = 0;
    tick(1'b1, 64);
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, 0);
      if (i >= 2 && k < 9) begin
        check("mid replay y", int'($signed(y)), imp_seq[k]);
        k++;
      end
    end

    // DC gain
    for (int i = 0; i < 20; i++) tick(1'b1, 100);
    check("dc 100", int'($signed(y)), 100);
    for (int i = 0; i < 20; i++) tick(1'b1, -128);
    check("dc -128", int'($signed(y)), -128);

    // Overflow pattern, oldest first
    ovf_seq = '{-128, 0, 127, 127, 127, 127, 0, -128};
    for (int i = 0; i < 8; i++) tick(1'b1, ovf_seq[i]);
    for (int i = 0; i < 3; i++) tick(1'b0, 0);
`ifdef AA_FIR_SAT_EN
    check("overflow y", int'($signed(y)), 127);
`else
    check("overflow y", int'($signed(y)), -121);
`endif
    tick(1'b0, 0);
    check("overflow hold", int'(y_valid), 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset(1);
      tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
